// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the write-back stage.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned PC_W_DEF       = 13;
   localparam int unsigned REG_ADDR_W_DEF = 3;
   localparam int unsigned CNT_W_DEF      = 16;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_LINK = 2'b10,
      WB_ILL  = 2'b11
   } wb_sel_e;

   // 2'b11 is not named; it is treated as a full word like SZ_WORD
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to write-back bundle: incoming instruction, hazard control and retire outputs.
interface writeback_stage_if import cpu_pkg::*; #(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned PC_W       = PC_W_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic                  in_valid;
   logic [PC_W-1:0]       pc_in;
   logic [DATA_W-1:0]     alu_res;
   logic [DATA_W-1:0]     mem_rdata;
   logic [OFF_W-1:0]      mem_off;
   logic [1:0]            mem_size;
   logic                  mem_signed;
   logic [1:0]            wb_sel;
   logic [REG_ADDR_W-1:0] wr_reg_in;
   logic                  wr_en_in;
   logic                  halt_in;
   logic                  stall;
   logic                  flush;

   logic [PC_W-1:0]       pc_out;
   logic                  rf_wr_en;
   logic [REG_ADDR_W-1:0] rf_wr_reg;
   logic [DATA_W-1:0]     rf_wr_data;
   logic                  fwd_valid;
   logic [CNT_W-1:0]      retire_cnt;
   logic                  halted;
   logic                  illegal;

   modport master (
      output in_valid, pc_in, alu_res, mem_rdata, mem_off, mem_size, mem_signed,
             wb_sel, wr_reg_in, wr_en_in, halt_in, stall, flush,
      input  pc_out, rf_wr_en, rf_wr_reg, rf_wr_data, fwd_valid, retire_cnt,
             halted, illegal
   );

   modport slave (
      input  in_valid, pc_in, alu_res, mem_rdata, mem_off, mem_size, mem_signed,
             wb_sel, wr_reg_in, wr_en_in, halt_in, stall, flush,
      output pc_out, rf_wr_en, rf_wr_reg, rf_wr_data, fwd_valid, retire_cnt,
             halted, illegal
   );

endinterface

// File: rtl/load_extend.sv
// Combinational load lane select with sign/zero extension of byte and half-word loads.
module load_extend import cpu_pkg::*; #(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        size,
   input  logic              sext,
   output logic [DATA_W-1:0] data
);

   logic [OFF_W-1:0]  half_off;
   logic [DATA_W-1:0] byte_sh;
   logic [DATA_W-1:0] half_sh;

   always_comb begin
      // Half-word lanes are aligned: the low offset bit never selects a lane
      half_off    = off;
      half_off[0] = 1'b0;
      byte_sh     = rdata >> {off, 3'b000};
      half_sh     = rdata >> {half_off, 3'b000};
      data        = rdata;
      case (mem_size_e'(size))
         SZ_BYTE: data = sext ? DATA_W'($signed(byte_sh[7:0]))  : DATA_W'(byte_sh[7:0]);
         SZ_HALF: data = sext ? DATA_W'($signed(half_sh[15:0])) : DATA_W'(half_sh[15:0]);
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Registered write-back stage: source select, load extension, write port/forwarding,
// saturating retire counter and sticky halt/illegal flags.
module writeback_stage import cpu_pkg::*; #(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter bit          ZERO_REG_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   writeback_stage_if.slave wb
);

   logic                  cap;
   logic                  wr;
   wb_sel_e               sel;
   logic [PC_W-1:0]       link_pc;
   logic [DATA_W-1:0]     load_data;
   logic [DATA_W-1:0]     sel_data;

   logic [PC_W-1:0]       pc_out;
   logic                  rf_wr_en;
   logic [REG_ADDR_W-1:0] rf_wr_reg;
   logic [DATA_W-1:0]     rf_wr_data;
   logic [CNT_W-1:0]      retire_cnt;
   logic                  halted;
   logic                  illegal;

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .rdata (wb.mem_rdata),
      .off   (wb.mem_off),
      .size  (wb.mem_size),
      .sext  (wb.mem_signed),
      .data  (load_data)
   );

   always_comb begin
      sel      = wb_sel_e'(wb.wb_sel);
      link_pc  = wb.pc_in + PC_W'(1);
      cap      = wb.in_valid & ~wb.stall & ~wb.flush & ~halted;
      wr       = wb.wr_en_in & (sel != WB_ILL) & ~(ZERO_REG_EN && (wb.wr_reg_in == '0));
      sel_data = '0;
      case (sel)
         WB_ALU:  sel_data = wb.alu_res;
         WB_MEM:  sel_data = load_data;
         WB_LINK: sel_data = DATA_W'(link_pc);
         default: sel_data = '0;
      endcase
   end

   // Retire registers load on every capture; only the write enable distinguishes a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out     <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_reg  <= '0;
         rf_wr_data <= '0;
         retire_cnt <= '0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         rf_wr_en <= 1'b0;
         if (cap) begin
            rf_wr_en   <= wr;
            pc_out     <= wb.pc_in;
            rf_wr_reg  <= wb.wr_reg_in;
            rf_wr_data <= sel_data;
            if (retire_cnt != '1)
               retire_cnt <= retire_cnt + CNT_W'(1);
            if (wb.halt_in)
               halted <= 1'b1;
            if (wb.wr_en_in && (sel == WB_ILL))
               illegal <= 1'b1;
         end
      end
   end

   assign wb.pc_out     = pc_out;
   assign wb.rf_wr_en   = rf_wr_en;
   assign wb.fwd_valid  = rf_wr_en;
   assign wb.rf_wr_reg  = rf_wr_reg;
   assign wb.rf_wr_data = rf_wr_data;
   assign wb.retire_cnt = retire_cnt;
   assign wb.halted     = halted;
   assign wb.illegal    = illegal;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: two instances (default config, and CNT_W=4 with ZERO_REG_EN=1) share stimulus.
module tb_writeback_stage;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, mem_signed, wr_en_in, halt_in, stall, flush;
   logic [12:0] pc_in;
   logic [31:0] alu_res, mem_rdata;
   logic [1:0]  mem_off, mem_size, wb_sel;
   logic [2:0]  wr_reg_in;

   writeback_stage_if #(.DATA_W(32), .PC_W(13), .REG_ADDR_W(3), .CNT_W(16)) ifa ();
   writeback_stage_if #(.DATA_W(32), .PC_W(13), .REG_ADDR_W(3), .CNT_W(4))  ifb ();

   writeback_stage #(.DATA_W(32), .PC_W(13), .REG_ADDR_W(3), .CNT_W(16), .ZERO_REG_EN(1'b0))
      dut_a (.clk(clk), .rst(rst), .wb(ifa.slave));
   writeback_stage #(.DATA_W(32), .PC_W(13), .REG_ADDR_W(3), .CNT_W(4), .ZERO_REG_EN(1'b1))
      dut_b (.clk(clk), .rst(rst), .wb(ifb.slave));

   assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;
   assign ifa.pc_in = pc_in;         assign ifb.pc_in = pc_in;
   assign ifa.alu_res = alu_res;     assign ifb.alu_res = alu_res;
   assign ifa.mem_rdata = mem_rdata; assign ifb.mem_rdata = mem_rdata;
   assign ifa.mem_off = mem_off;     assign ifb.mem_off = mem_off;
   assign ifa.mem_size = mem_size;   assign ifb.mem_size = mem_size;
   assign ifa.mem_signed = mem_signed; assign ifb.mem_signed = mem_signed;
   assign ifa.wb_sel = wb_sel;       assign ifb.wb_sel = wb_sel;
   assign ifa.wr_reg_in = wr_reg_in; assign ifb.wr_reg_in = wr_reg_in;
   assign ifa.wr_en_in = wr_en_in;   assign ifb.wr_en_in = wr_en_in;
   assign ifa.halt_in = halt_in;     assign ifb.halt_in = halt_in;
   assign ifa.stall = stall;         assign ifb.stall = stall;
   assign ifa.flush = flush;         assign ifb.flush = flush;

   logic        o_en [2], o_fwd [2], o_halt [2], o_ill [2];
   logic [2:0]  o_reg [2];
   logic [12:0] o_pc [2];
   logic [31:0] o_data [2];
   logic [15:0] o_cnt [2];

   assign o_en[0] = ifa.rf_wr_en;     assign o_en[1] = ifb.rf_wr_en;
   assign o_fwd[0] = ifa.fwd_valid;   assign o_fwd[1] = ifb.fwd_valid;
   assign o_halt[0] = ifa.halted;     assign o_halt[1] = ifb.halted;
   assign o_ill[0] = ifa.illegal;     assign o_ill[1] = ifb.illegal;
   assign o_reg[0] = ifa.rf_wr_reg;   assign o_reg[1] = ifb.rf_wr_reg;
   assign o_pc[0] = ifa.pc_out;       assign o_pc[1] = ifb.pc_out;
   assign o_data[0] = ifa.rf_wr_data; assign o_data[1] = ifb.rf_wr_data;
   assign o_cnt[0] = ifa.retire_cnt;  assign o_cnt[1] = 16'(ifb.retire_cnt);

   // Reference state per instance: what the write port should show after each edge
   logic        m_en [2], m_halt [2], m_ill [2], m_dk [2];
   logic [2:0]  m_reg [2];
   logic [12:0] m_pc [2];
   logic [31:0] m_data [2];
   int unsigned m_cnt [2];
   int unsigned cnt_max [2] = '{65535, 15};
   bit          zero_en [2] = '{1'b0, 1'b1};

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] ref_data(logic [1:0] sel, logic [31:0] alu, logic [12:0] pc,
                                            logic [31:0] rd, logic [1:0] off, logic [1:0] sz, logic sg);
      longint unsigned v;
      v = 0;
      case (sel)
         2'd0: v = alu;
         2'd2: v = (longint'(pc) + 1) % 8192;
         2'd1: begin
            if (sz == 2'd0) begin
               v = (longint'(rd) / (longint'(1) << (8 * int'(off)))) % 256;
               if (sg && v >= 128) v = v + 64'hFFFF_FF00;
            end else if (sz == 2'd1) begin
               v = (longint'(rd) / (longint'(1) << (16 * (int'(off) / 2)))) % 65536;
               if (sg && v >= 32768) v = v + 64'hFFFF_0000;
            end else begin
               v = rd;
            end
         end
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   task automatic idle();
      in_valid = 0; stall = 0; flush = 0; halt_in = 0; wr_en_in = 0; wb_sel = 0;
      pc_in = 0; alu_res = 0; mem_rdata = 0; mem_off = 0; mem_size = 0; mem_signed = 0;
      wr_reg_in = 0;
   endtask

   task automatic tick();
      logic cap;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_en[k] = 0; m_halt[k] = 0; m_ill[k] = 0; m_dk[k] = 1;
            m_reg[k] = 0; m_pc[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
         end else begin
            cap = in_valid && !stall && !flush && !m_halt[k];
            m_en[k] = 0;
            if (cap) begin
               m_en[k]   = wr_en_in && (wb_sel != 2'd3) && !(zero_en[k] && wr_reg_in == 0);
               m_pc[k]   = pc_in;
               m_reg[k]  = wr_reg_in;
               m_dk[k]   = (wb_sel != 2'd3);
               m_data[k] = ref_data(wb_sel, alu_res, pc_in, mem_rdata, mem_off, mem_size, mem_signed);
               if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
               if (halt_in) m_halt[k] = 1;
               if (wr_en_in && wb_sel == 2'd3) m_ill[k] = 1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1; in_valid = 1; wr_en_in = 1; alu_res = 32'hDEAD_BEEF; wr_reg_in = 3'd6;
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({o_en[k], o_fwd[k], o_halt[k], o_ill[k], o_reg[k], o_pc[k], o_data[k], o_cnt[k]} !== '0) begin
            bad++;
            $display("FAIL reset dut%0d got en=%b fwd=%b halt=%b ill=%b reg=%h pc=%h data=%h cnt=%0d exp all zero",
                     k, o_en[k], o_fwd[k], o_halt[k], o_ill[k], o_reg[k], o_pc[k], o_data[k], o_cnt[k]);
         end
      end
      rst = 0; idle();
   endtask

   task automatic test_alu();
      idle(); in_valid = 1; wr_en_in = 1; wb_sel = 2'd0; alu_res = 32'h1234_5678;
      wr_reg_in = 3'd5; pc_in = 13'h042;
      tick();
      idle();
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({o_en[k], o_fwd[k], o_reg[k], o_data[k], o_pc[k]} !== {1'b1, 1'b1, 3'd5, 32'h1234_5678, 13'h042}) begin
            bad++;
            $display("FAIL alu dut%0d got en=%b fwd=%b reg=%0d data=%h pc=%h exp en=1 fwd=1 reg=5 data=12345678 pc=042",
                     k, o_en[k], o_fwd[k], o_reg[k], o_data[k], o_pc[k]);
         end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({o_en[k], o_fwd[k], o_data[k], o_reg[k]} !== {1'b0, 1'b0, 32'h1234_5678, 3'd5}) begin
            bad++;
            $display("FAIL alu_bubble dut%0d got en=%b fwd=%b data=%h reg=%0d exp en=0 fwd=0 data=12345678 reg=5",
                     k, o_en[k], o_fwd[k], o_data[k], o_reg[k]);
         end
      end
   endtask

   task automatic test_loads();
      logic [1:0]  t_sz [7]  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1};
      logic [1:0]  t_off [7] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
      logic        t_sg [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] t_exp [7] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_0001,
                                 32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_7F01};
      for (int i = 0; i < 7; i++) begin
         idle(); in_valid = 1; wr_en_in = 1; wb_sel = 2'd1; wr_reg_in = 3'd2;
         mem_rdata = 32'h80FF_7F01; mem_size = t_sz[i]; mem_off = t_off[i]; mem_signed = t_sg[i];
         tick();
         total++;
         if (o_data[0] !== t_exp[i] || o_en[0] !== 1'b1) begin
            bad++;
            $display("FAIL load_dir%0d got data=%h en=%b exp data=%h en=1", i, o_data[0], o_en[0], t_exp[i]);
         end
      end
      for (int i = 0; i < 40; i++) begin
         idle(); in_valid = 1; wr_en_in = 1; wb_sel = 2'd1; wr_reg_in = 3'($urandom);
         mem_rdata = $urandom; mem_size = 2'($urandom); mem_off = 2'($urandom); mem_signed = 1'($urandom);
         tick();
         total++;
         if (o_data[0] !== m_data[0]) begin
            bad++;
            $display("FAIL load_rand%0d got=%h exp=%h", i, o_data[0], m_data[0]);
         end
      end
   endtask

   task automatic test_link();
      logic [12:0] t_pc [2]  = '{13'h1FFF, 13'h0010};
      logic [31:0] t_exp [2] = '{32'h0000_0000, 32'h0000_0011};
      for (int i = 0; i < 2; i++) begin
         idle(); in_valid = 1; wr_en_in = 1; wb_sel = 2'd2; wr_reg_in = 3'd1; pc_in = t_pc[i];
         alu_res = 32'hFFFF_FFFF;
         tick();
         total++;
         if (o_data[0] !== t_exp[i] || o_pc[0] !== t_pc[i]) begin
            bad++;
            $display("FAIL link%0d got data=%h pc=%h exp data=%h pc=%h", i, o_data[0], o_pc[0], t_exp[i], t_pc[i]);
         end
      end
   endtask

   task automatic test_stall_flush();
      int unsigned base;
      base = m_cnt[0];
      idle(); in_valid = 1; wr_en_in = 1; wr_reg_in = 3'd4; alu_res = 32'hCAFE_0001; stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (o_en[0] !== 1'b0 || o_fwd[0] !== 1'b0) begin
            bad++;
            $display("FAIL stall_bubble%0d got en=%b fwd=%b exp 0", i, o_en[0], o_fwd[0]);
         end
      end
      stall = 0;
      tick();
      in_valid = 0;
      total++;
      if (o_en[0] !== 1'b1 || o_data[0] !== 32'hCAFE_0001) begin
         bad++;
         $display("FAIL stall_release got en=%b data=%h exp en=1 data=cafe0001", o_en[0], o_data[0]);
      end
      tick();
      total++;
      if (o_cnt[0] !== 16'(base + 1) || o_en[0] !== 1'b0) begin
         bad++;
         $display("FAIL stall_count got cnt=%0d en=%b exp cnt=%0d en=0", o_cnt[0], o_en[0], base + 1);
      end
      in_valid = 1; stall = 1; flush = 1;
      tick();
      stall = 0;
      tick();
      idle();
      total++;
      if (o_en[0] !== 1'b0 || o_cnt[0] !== 16'(base + 1)) begin
         bad++;
         $display("FAIL flush got en=%b cnt=%0d exp en=0 cnt=%0d", o_en[0], o_cnt[0], base + 1);
      end
   endtask

   task automatic test_zero_reg_illegal();
      int unsigned base;
      base = m_cnt[0];
      idle(); in_valid = 1; wr_en_in = 1; wr_reg_in = 3'd0; alu_res = 32'h0000_0077;
      tick();
      total++;
      if (o_en[0] !== 1'b1 || o_en[1] !== 1'b0 || o_cnt[0] !== 16'(base + 1) || o_cnt[1] !== 16'(m_cnt[1])) begin
         bad++;
         $display("FAIL zero_reg got en_a=%b en_b=%b cnt_a=%0d cnt_b=%0d exp en_a=1 en_b=0 cnt_a=%0d cnt_b=%0d",
                  o_en[0], o_en[1], o_cnt[0], o_cnt[1], base + 1, m_cnt[1]);
      end
      wb_sel = 2'd3; wr_reg_in = 3'd3;
      tick();
      idle();
      total++;
      if (o_en[0] !== 1'b0 || o_ill[0] !== 1'b1 || o_ill[1] !== 1'b1 || o_cnt[0] !== 16'(base + 2)) begin
         bad++;
         $display("FAIL illegal got en=%b ill_a=%b ill_b=%b cnt=%0d exp en=0 ill=1 cnt=%0d",
                  o_en[0], o_ill[0], o_ill[1], o_cnt[0], base + 2);
      end
      rst = 1; in_valid = 1; wr_en_in = 1;
      tick();
      rst = 0; idle();
      total++;
      if (o_ill[0] !== 1'b0 || o_en[0] !== 1'b0 || o_cnt[0] !== 16'd0) begin
         bad++;
         $display("FAIL midreset got ill=%b en=%b cnt=%0d exp 0", o_ill[0], o_en[0], o_cnt[0]);
      end
   endtask

   task automatic test_saturation();
      rst = 1; tick(); rst = 0;
      idle(); in_valid = 1;
      for (int i = 0; i < 20; i++) begin
         pc_in = 13'(i);
         tick();
      end
      idle();
      total++;
      if (o_cnt[1] !== 16'd15 || o_cnt[0] !== 16'd20) begin
         bad++;
         $display("FAIL saturate got cnt_b=%0d cnt_a=%0d exp cnt_b=15 cnt_a=20", o_cnt[1], o_cnt[0]);
      end
   endtask

   task automatic test_halt();
      rst = 1; tick(); rst = 0;
      idle(); in_valid = 1; wr_en_in = 1; halt_in = 1; wr_reg_in = 3'd3; alu_res = 32'h0000_0ABC; pc_in = 13'h100;
      tick();
      halt_in = 0;
      total++;
      if (o_en[0] !== 1'b1 || o_data[0] !== 32'h0000_0ABC || o_halt[0] !== 1'b1 || o_cnt[0] !== 16'd1) begin
         bad++;
         $display("FAIL halt_retire got en=%b data=%h halted=%b cnt=%0d exp en=1 data=abc halted=1 cnt=1",
                  o_en[0], o_data[0], o_halt[0], o_cnt[0]);
      end
      for (int i = 0; i < 3; i++) begin
         pc_in = 13'h200 + 13'(i); alu_res = $urandom;
         tick();
         total++;
         if (o_en[0] !== 1'b0 || o_en[1] !== 1'b0 || o_cnt[0] !== 16'd1 || o_pc[0] !== 13'h100) begin
            bad++;
            $display("FAIL halted_hold%0d got en=%b/%b cnt=%0d pc=%h exp en=0 cnt=1 pc=100",
                     i, o_en[0], o_en[1], o_cnt[0], o_pc[0]);
         end
      end
      rst = 1; tick(); rst = 0; idle();
      total++;
      if (o_halt[0] !== 1'b0 || o_halt[1] !== 1'b0) begin
         bad++;
         $display("FAIL halt_clear got %b/%b exp 0", o_halt[0], o_halt[1]);
      end
   endtask

   task automatic test_random();
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 300; i++) begin
         rst        = ($urandom_range(63) == 0);
         in_valid   = ($urandom_range(3) != 0);
         stall      = ($urandom_range(7) == 0);
         flush      = ($urandom_range(7) == 0);
         halt_in    = ($urandom_range(99) == 0);
         wr_en_in   = ($urandom_range(7) != 0);
         wb_sel     = 2'($urandom);
         wr_reg_in  = 3'($urandom);
         pc_in      = 13'($urandom);
         alu_res    = $urandom;
         mem_rdata  = $urandom;
         mem_off    = 2'($urandom);
         mem_size   = 2'($urandom);
         mem_signed = 1'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (o_en[k] !== m_en[k] || o_fwd[k] !== m_en[k] || o_reg[k] !== m_reg[k] || o_pc[k] !== m_pc[k] ||
                (m_dk[k] && o_data[k] !== m_data[k]) || o_cnt[k] !== 16'(m_cnt[k]) ||
                o_halt[k] !== m_halt[k] || o_ill[k] !== m_ill[k]) begin
               bad++;
               $display("FAIL rand dut%0d cyc%0d got en=%b fwd=%b reg=%0d pc=%h data=%h cnt=%0d halt=%b ill=%b exp en=%b reg=%0d pc=%h data=%h cnt=%0d halt=%b ill=%b",
                        k, i, o_en[k], o_fwd[k], o_reg[k], o_pc[k], o_data[k], o_cnt[k], o_halt[k], o_ill[k],
                        m_en[k], m_reg[k], m_pc[k], m_data[k], m_cnt[k], m_halt[k], m_ill[k]);
            end
         end
      end
      rst = 0; idle();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_alu();
      test_loads();
      test_link();
      test_stall_flush();
      test_zero_reg_illegal();
      test_saturation();
      test_halt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised, registered successor to the combinational write-back block; final pipeline stage before the register file.
- Selects the write-back source: ALU result, extended memory load, or PC link.
- Extends sub-word loads and registers the write port.
- Drives a forwarding bus, a retired-instruction counter and a sticky halt flag, with stall/flush control from hazard logic.

Parameters:
DATA_W, 32, datapath width; multiple of 16, >= PC_W
PC_W, 13, program counter width
REG_ADDR_W, 3, register index width
CNT_W, 16, retired-instruction counter width
ZERO_REG_EN, 0, 1 = writes to register 0 are suppressed

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  memory stage presents a real instruction
pc_in  in  PC_W  PC of incoming instruction
alu_res  in  DATA_W  ALU result
mem_rdata  in  DATA_W  raw memory read word
mem_off  in  log2(DATA_W/8)  byte offset of the load address
mem_size  in  2  00 byte, 01 half, 10/11 word
mem_signed  in  1  1 = sign-extend sub-word load
wb_sel  in  2  00 ALU, 01 MEM, 10 PC link, 11 illegal
wr_reg_in  in  REG_ADDR_W  destination register
wr_en_in  in  1  instruction writes a register
halt_in  in  1  instruction is HALT
stall  in  1  insert a bubble; upstream holds its instruction
flush  in  1  kill the incoming instruction
pc_out  out  PC_W  PC of retired instruction
rf_wr_en  out  1  register-file write enable (one-cycle pulse)
rf_wr_reg  out  REG_ADDR_W  write address
rf_wr_data  out  DATA_W  write data
fwd_valid  out  1  forwarding bus valid (equals rf_wr_en)
retire_cnt  out  CNT_W  retired-instruction count, saturating
halted  out  1  sticky: HALT has retired
illegal  out  1  sticky: wb_sel=11 seen on a valid write

Behaviour:
- Reset (rst=1 at clk edge) clears all outputs, counters and sticky flags, and takes priority over everything. Mid-operation reset discards the in-flight instruction.
- Capture condition: cap = in_valid & ~stall & ~flush & ~halted.
  - Priority order: rst > flush > stall > capture.
  - Latency: outputs reflect the captured instruction exactly one cycle after the capture edge.
- Without cap at an edge, rf_wr_en and fwd_valid go 0 (bubble). pc_out, rf_wr_reg and rf_wr_data hold their last values.
- Write-enable, registered on cap:
  - rf_wr_en = wr_en_in & ~(ZERO_REG_EN & wr_reg_in==0) & (wb_sel!=11).
  - wb_sel=11 with wr_en_in=1 sets illegal; write suppressed; instruction still retires.
- Data selection (combinational before the register):
  - ALU: alu_res.
  - PC link: (pc_in+1) mod 2^PC_W, zero-extended to DATA_W.
  - MEM, byte: lane mem_rdata[8*mem_off +: 8].
  - MEM, half: lane mem_rdata[16*mem_off[msb:1] +: 16]; mem_off[0] is ignored.
  - MEM, word: mem_rdata unchanged; mem_off is ignored.
  - Sub-word lanes are sign-extended when mem_signed=1, else zero-extended.
- retire_cnt increments by 1 on every cap, including non-writing instructions, and saturates at 2^CNT_W-1.
- Halt:
  - cap with halt_in=1 sets halted on that edge; the HALT's own write still occurs if enabled.
  - While halted, cap=0: no further writes, counter frozen. Only rst clears halted.
- Simultaneous stall and flush: flush wins; the result is a bubble either way.
- The forwarding bus is the write port itself: fwd_valid=rf_wr_en, with reg/data shared.

Decomposition:
- Package cpu_pkg holds:
  - wb_sel encodings WB_ALU, WB_MEM, WB_LINK, WB_ILL;
  - mem_size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - default widths.
- Sub-module load_extend (combinational lane select plus sign/zero extension, parametrised by DATA_W) is instantiated once.

Test Plan:
- Reset: assert rst with in_valid=1 and wr_en_in=1 -> all outputs 0 the next cycle; halted=0, retire_cnt=0.
- ALU path: alu_res=0x1234_5678, wb_sel=00, wr_reg_in=5 -> after 1 cycle, rf_wr_en=1, rf_wr_reg=5, rf_wr_data=0x12345678; rf_wr_en=0 the following cycle if in_valid=0.
- Loads with mem_rdata=0x80FF_7F01:
  - byte, off=2, signed -> 0xFFFFFFFF;
  - byte, off=2, unsigned -> 0x000000FF;
  - half, off=2, signed -> 0xFFFF80FF;
  - byte, off=0, signed -> 0x00000001.
- Link: pc_in=0x1FFF, wb_sel=10 -> rf_wr_data=0x00000000 (wrap); pc_in=0x0010 -> 0x00000011.
- Stall/flush:
  - stall=1 for 2 cycles then valid -> two bubbles, then a single write; retire_cnt +1 total.
  - flush and stall together -> bubble, no count.
- Halt/saturation/zero register:
  - HALT retires -> halted=1; later valid writes produce no rf_wr_en.
  - CNT_W=4 with 20 instructions -> retire_cnt=15.
  - ZERO_REG_EN=1 with wr_reg_in=0 -> rf_wr_en=0, retire_cnt still increments.
